// File: rtl/lap_record_ctrl_pkg.sv
// Shared widths, state encoding and time-word packing for the lap-memory controller.
package lap_record_ctrl_pkg;

    localparam int TIME_W = 19;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MS_W   = 7;

    typedef enum logic {
        ST_LIVE   = 1'b0,
        ST_REVIEW = 1'b1
    } state_t;

    function automatic logic [TIME_W-1:0] pack_time(
        input logic [MIN_W-1:0] min_v,
        input logic [SEC_W-1:0] sec_v,
        input logic [MS_W-1:0]  ms_v
    );
        return {min_v, sec_v, ms_v};
    endfunction

endpackage

// File: rtl/lap_record_ctrl_ram.sv
// Lap storage: DEPTH x TIME_W register file, one synchronous write port, one
// asynchronous read port. Storage is deliberately not reset.
module lap_record_ctrl_ram
    import lap_record_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [TIME_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [TIME_W-1:0] rdata
);

    logic [TIME_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lap_record_ctrl.sv
// Lap-memory controller: records live time into a circular lap buffer and steps
// through stored laps newest-to-oldest in REVIEW, muxing live/recalled time to the display.
module lap_record_ctrl
    import lap_record_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rec_p,
    input  logic             rev_p,
    input  logic             clr_p,
    input  logic             running_i,
    input  logic [MIN_W-1:0] min_i,
    input  logic [SEC_W-1:0] sec_i,
    input  logic [MS_W-1:0]  ms_10_i,
    output logic [MIN_W-1:0] min_o,
    output logic [SEC_W-1:0] sec_o,
    output logic [MS_W-1:0]  ms_10_o,
    output logic             review_o,
    output logic [IDX_W-1:0] lap_idx_o,
    output logic [IDX_W:0]   lap_cnt_o,
    output logic             full_o
);

    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wr_ptr_q, rd_off_q, rd_addr;
    logic [IDX_W:0]    lap_cnt_q;
    logic              wr_en, step_en, full;
    logic [TIME_W-1:0] live_word, rd_word, disp_p1;

    assign full      = (lap_cnt_q == CNT_FULL);
    assign live_word = pack_time(min_i, sec_i, ms_10_i);
    // Newest lap sits just behind the write pointer; rd_off walks back toward older laps.
    assign rd_addr   = wr_ptr_q - PTR_ONE - rd_off_q;

    lap_record_ctrl_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (live_word),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = ST_LIVE;
        end else if (rev_p) begin
            if (state_q == ST_REVIEW) begin
                state_d = ST_LIVE;
            end else if (lap_cnt_q != '0) begin
                state_d = ST_REVIEW;
            end
        end
    end

    // rec_p only acts when neither higher-priority request is present this cycle.
    always_comb begin
        wr_en   = 1'b0;
        step_en = 1'b0;
        if (!clr_p && !rev_p && rec_p) begin
            if (state_q == ST_LIVE) begin
                wr_en = running_i;
            end else begin
                step_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            lap_cnt_q <= '0;
            rd_off_q  <= '0;
        end else if (clr_p) begin
            wr_ptr_q  <= '0;
            lap_cnt_q <= '0;
            rd_off_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (!full) begin
                    lap_cnt_q <= lap_cnt_q + CNT_ONE;
                end
            end
            if (rev_p) begin
                rd_off_q <= '0;
            end else if (step_en) begin
                rd_off_q <= ({1'b0, rd_off_q} == (lap_cnt_q - CNT_ONE)) ? '0 : rd_off_q + PTR_ONE;
            end
        end
    end

    // Display stage: one cycle behind the live inputs or the current recall offset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_p1 <= '0;
        end else begin
            disp_p1 <= (state_q == ST_REVIEW) ? rd_word : live_word;
        end
    end

    assign min_o     = disp_p1[TIME_W-1 -: MIN_W];
    assign sec_o     = disp_p1[MS_W +: SEC_W];
    assign ms_10_o   = disp_p1[MS_W-1:0];
    assign review_o  = (state_q == ST_REVIEW);
    assign lap_idx_o = rd_off_q;
    assign lap_cnt_o = lap_cnt_q;
    assign full_o    = full;

endmodule

// File: tb/tb_lap_record_ctrl.sv
// Directed bench for lap_record_ctrl: table of single-cycle vectors plus
// hand-written sequences for buffer wrap-around and asynchronous reset.
module tb_lap_record_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rec_p, rev_p, clr_p, running_i;
    logic [5:0] min_i, sec_i;
    logic [6:0] ms_10_i;
    logic [5:0] min_o, sec_o;
    logic [6:0] ms_10_o;
    logic       review_o;
    logic [2:0] lap_idx_o;
    logic [3:0] lap_cnt_o;
    logic       full_o;

    int n_total = 0;
    int n_pass  = 0;

    lap_record_ctrl #(.DEPTH(8), .IDX_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .rec_p     (rec_p),
        .rev_p     (rev_p),
        .clr_p     (clr_p),
        .running_i (running_i),
        .min_i     (min_i),
        .sec_i     (sec_i),
        .ms_10_i   (ms_10_i),
        .min_o     (min_o),
        .sec_o     (sec_o),
        .ms_10_o   (ms_10_o),
        .review_o  (review_o),
        .lap_idx_o (lap_idx_o),
        .lap_cnt_o (lap_cnt_o),
        .full_o    (full_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rec, rev, clr, run;
        logic [5:0] mi, se;
        logic [6:0] ms;
        logic       e_rev;
        logic [2:0] e_idx;
        logic [3:0] e_cnt;
        logic       e_full;
        logic [5:0] e_mi, e_se;
        logic [6:0] e_ms;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic rec, input logic rev, input logic clr, input logic run,
        input int mi, input int se, input int ms,
        input logic e_rev, input int e_idx, input int e_cnt, input logic e_full,
        input int e_mi, input int e_se, input int e_ms
    );
        vec_t v;
        v.rec = rec; v.rev = rev; v.clr = clr; v.run = run;
        v.mi = 6'(mi); v.se = 6'(se); v.ms = 7'(ms);
        v.e_rev = e_rev; v.e_idx = 3'(e_idx); v.e_cnt = 4'(e_cnt); v.e_full = e_full;
        v.e_mi = 6'(e_mi); v.e_se = 6'(e_se); v.e_ms = 7'(e_ms);
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all(input string tag, input logic e_rev, input int e_idx, input int e_cnt,
                             input logic e_full, input int e_mi, input int e_se, input int e_ms);
        cmp({tag, ".review"}, 32'(review_o), 32'(e_rev));
        cmp({tag, ".idx"},    32'(lap_idx_o), 32'(e_idx));
        cmp({tag, ".cnt"},    32'(lap_cnt_o), 32'(e_cnt));
        cmp({tag, ".full"},   32'(full_o), 32'(e_full));
        cmp({tag, ".min"},    32'(min_o), 32'(e_mi));
        cmp({tag, ".sec"},    32'(sec_o), 32'(e_se));
        cmp({tag, ".ms"},     32'(ms_10_o), 32'(e_ms));
    endtask

    task automatic step(input logic rec, input logic rev, input logic clr, input logic run,
                        input int mi, input int se, input int ms);
        rec_p = rec; rev_p = rev; clr_p = clr; running_i = run;
        min_i = 6'(mi); sec_i = 6'(se); ms_10_i = 7'(ms);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Recording, review stepping/wrap, priority and ignored requests.
        vecs[0]  = mk(1,0,0,1, 1,2,3,   0,0,1,0, 1,2,3);
        vecs[1]  = mk(0,1,0,1, 1,2,3,   1,0,1,0, 1,2,3);
        vecs[2]  = mk(0,0,0,1, 5,5,5,   1,0,1,0, 1,2,3);
        vecs[3]  = mk(0,1,0,1, 5,5,5,   0,0,1,0, 1,2,3);
        vecs[4]  = mk(0,0,0,1, 5,5,5,   0,0,1,0, 5,5,5);
        vecs[5]  = mk(0,0,1,1, 5,5,5,   0,0,0,0, 5,5,5);
        vecs[6]  = mk(1,0,0,1, 0,10,0,  0,0,1,0, 0,10,0);
        vecs[7]  = mk(1,0,0,1, 0,20,0,  0,0,2,0, 0,20,0);
        vecs[8]  = mk(1,0,0,1, 0,30,0,  0,0,3,0, 0,30,0);
        vecs[9]  = mk(0,1,0,1, 0,40,0,  1,0,3,0, 0,40,0);
        vecs[10] = mk(0,0,0,1, 0,40,0,  1,0,3,0, 0,30,0);
        vecs[11] = mk(1,0,0,1, 0,40,0,  1,1,3,0, 0,30,0);
        vecs[12] = mk(0,0,0,1, 0,40,0,  1,1,3,0, 0,20,0);
        vecs[13] = mk(1,0,0,1, 0,40,0,  1,2,3,0, 0,20,0);
        vecs[14] = mk(0,0,0,1, 0,40,0,  1,2,3,0, 0,10,0);
        vecs[15] = mk(1,0,0,1, 0,40,0,  1,0,3,0, 0,10,0);
        vecs[16] = mk(0,0,0,1, 0,40,0,  1,0,3,0, 0,30,0);
        vecs[17] = mk(1,0,0,1, 0,40,0,  1,1,3,0, 0,30,0);
        vecs[18] = mk(1,1,0,1, 0,40,0,  0,0,3,0, 0,20,0);
        vecs[19] = mk(0,0,0,1, 0,40,0,  0,0,3,0, 0,40,0);
        vecs[20] = mk(0,1,0,1, 0,40,0,  1,0,3,0, 0,40,0);
        vecs[21] = mk(0,1,1,1, 0,40,0,  0,0,0,0, 0,30,0);
        vecs[22] = mk(0,0,0,1, 0,40,0,  0,0,0,0, 0,40,0);
        vecs[23] = mk(1,0,0,0, 0,41,0,  0,0,0,0, 0,41,0);
        vecs[24] = mk(1,0,0,1, 0,42,0,  0,0,1,0, 0,42,0);
        vecs[25] = mk(1,0,0,0, 0,43,0,  0,0,1,0, 0,43,0);
        vecs[26] = mk(1,0,1,1, 0,44,0,  0,0,0,0, 0,44,0);
        vecs[27] = mk(0,1,0,1, 0,45,0,  0,0,0,0, 0,45,0);
        vecs[28] = mk(0,0,0,1, 0,45,0,  0,0,0,0, 0,45,0);

        rst = 1'b0;
        rec_p = 0; rev_p = 0; clr_p = 0; running_i = 0;
        min_i = 0; sec_i = 0; ms_10_i = 0;
        #12;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rec, vecs[i].rev, vecs[i].clr, vecs[i].run,
                 int'(vecs[i].mi), int'(vecs[i].se), int'(vecs[i].ms));
            check_all($sformatf("v%0d", i), vecs[i].e_rev, int'(vecs[i].e_idx),
                      int'(vecs[i].e_cnt), vecs[i].e_full,
                      int'(vecs[i].e_mi), int'(vecs[i].e_se), int'(vecs[i].e_ms));
        end

        // Ten laps into eight slots: laps 1-2 are overwritten, lap 3 becomes oldest.
        step(0,0,1,1, 0,0,0);
        for (int i = 1; i <= 10; i++) begin
            step(1,0,0,1, 0,0,i);
        end
        check_all("ovf.full", 0, 0, 8, 1, 0, 0, 10);
        step(0,1,0,1, 0,59,99);
        step(0,0,0,1, 0,59,99);
        check_all("ovf.newest", 1, 0, 8, 1, 0, 0, 10);
        for (int k = 0; k < 7; k++) begin
            step(1,0,0,1, 0,59,99);
            step(0,0,0,1, 0,59,99);
        end
        check_all("ovf.oldest", 1, 7, 8, 1, 0, 0, 3);
        step(1,0,0,1, 0,59,99);
        step(0,0,0,1, 0,59,99);
        check_all("ovf.wrap", 1, 0, 8, 1, 0, 0, 10);

        // Asynchronous reset in REVIEW clears outputs without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_all("arst.during", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step(0,0,0,1, 2,3,4);
        check_all("arst.after", 0, 0, 0, 0, 2, 3, 4);
        step(0,1,0,1, 2,3,5);
        check_all("arst.rev_empty", 0, 0, 0, 0, 2, 3, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
